// File: rtl/mem_arbiter.sv
// Arbiter sharing one fixed-latency, single-port memory between instruction fetch
// and data access; data has priority, with a starvation guard that forces a fetch grant.
module mem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_fetch,
  output logic              stall_mem,
  output logic              busy
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [STV_W-1:0]  r_starve;
  logic              r_src;      // 1 = data requester owns the access
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic w_any_req, w_grant_d, w_last;

  assign w_any_req = if_req | d_req;
  assign w_grant_d = d_req & ~(if_req & (r_starve == STV_MAX));
  assign w_last    = (r_cnt == '0);

  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any_req) w_next = S_ACCESS;
      S_ACCESS: if (w_last)    w_next = S_RESP;
      S_RESP:                  w_next = S_IDLE;
      default:                 w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_starve   <= '0;
      r_src      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_cnt   <= CNT_INIT;
            r_src   <= w_grant_d;
            r_we    <= w_grant_d & d_we;
            r_addr  <= w_grant_d ? d_addr : if_addr;
            r_wdata <= w_grant_d ? d_wdata : '0;
            // A contested data win implies r_starve < STV_MAX, so this saturates
            if (!w_grant_d)  r_starve <= '0;
            else if (if_req) r_starve <= r_starve + 1'b1;
          end
        end
        S_ACCESS: begin
          if (!w_last) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (!r_we) begin
            if (r_src) r_d_rdata  <= mem_rdata;
            else       r_if_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_en      = (r_state == S_ACCESS);
  assign mem_we      = mem_en & r_we;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign if_ack      = (r_state == S_RESP) & ~r_src;
  assign d_ack       = (r_state == S_RESP) &  r_src;
  assign if_rdata    = r_if_rdata;
  assign d_rdata     = r_d_rdata;
  assign stall_fetch = if_req & ~if_ack;
  assign stall_mem   = d_req & ~d_ack;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares a single-port, fixed-latency unified memory between the instruction-fetch stage and the data-memory stage of the MIPS pipeline.
- Arbitrates between the two requesters, sequences each memory access and returns read data with a one-cycle acknowledge.
- Drives stall signals that freeze the pipeline registers and PC while an access is pending.
- Sits between the pipeline (PC/fetch buffer, data-memory access) and the shared memory array.

Parameters:
ADDR_W, 8, memory address width (word addresses)
DATA_W, 32, data width
MEM_LAT, 2, cycles the memory needs per access (>=1); address/control held stable for all of them
STARVE_MAX, 3, consecutive lost arbitrations after which fetch is forced to win

Ports:
clock  in  1  single system clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset
if_req  in  1  fetch request; held with if_addr stable until if_ack
if_addr  in  ADDR_W  fetch address
if_ack  out  1  one-cycle pulse: fetch complete, if_rdata valid
if_rdata  out  DATA_W  registered fetch data; holds last value between acks
d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_ack
d_we  in  1  1 = write (SW), 0 = read (LW)
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_ack  out  1  one-cycle pulse: data access complete
d_rdata  out  DATA_W  registered load data; updated only on read acks
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid in last access cycle
stall_fetch  out  1  if_req & ~if_ack (combinational)
stall_mem  out  1  d_req & ~d_ack (combinational)
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset (reset==0 at an edge):
  - State goes to IDLE.
  - mem_en, mem_we, if_ack and d_ack are 0.
  - if_rdata, d_rdata, mem_addr and mem_wdata are 0.
  - Latency and starvation counters are 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Arbitrates only in this state.
  - If any request is present, the winner's command is latched (addr, we, wdata, source id) and the FSM moves to ACCESS with the counter = MEM_LAT-1.
  - With no request, stays in IDLE.
- Arbitration:
  - Data wins over fetch by default.
  - Fetch wins when both request and starve_cnt == STARVE_MAX.
  - When both request and data wins, starve_cnt increments, saturating at STARVE_MAX.
  - A fetch grant clears starve_cnt.
  - A fetch grant with no data request also clears it.
- ACCESS:
  - mem_en=1; mem_addr/mem_wdata come from the latched command.
  - mem_we=1 only for a data write.
  - Counter decrements each cycle.
  - When counter==0 and the access is a read, mem_rdata is captured into if_rdata or d_rdata (by source) and the FSM moves to RESP.
  - Total ACCESS duration is exactly MEM_LAT cycles.
- RESP:
  - Pulses exactly one of if_ack/d_ack for one cycle; mem_en=0, mem_we=0.
  - Always returns to IDLE; no arbitration in RESP.
  - The requester must drop or renew its request in the cycle after the ack.
- Latency: request first sampled at edge k gives ACCESS in cycles k+1..k+MEM_LAT and ack in cycle k+MEM_LAT+1. Minimum spacing between accesses is MEM_LAT+2 cycles.
- Writes: d_ack is pulsed; d_rdata and if_rdata are unchanged.
- Requester drops req during ACCESS: the access still completes and the ack still pulses; the requester ignores it.
- Latched command is immune to input changes after grant.
- Reset low mid-ACCESS/RESP: at that edge the access is aborted and no ack is issued. A still-pending request is arbitrated again once reset returns high.

Test Plan:
- Single fetch: MEM_LAT=2, after reset if_req=1, if_addr=8'h10, memory returns 32'hDEADBEEF → mem_en high cycles 1-2 with mem_addr=8'h10, mem_we=0; if_ack in cycle 3 with if_rdata=32'hDEADBEEF; stall_fetch high cycles 0-2 and low in cycle 3.
- Simultaneous reads: if_req (8'h04) and d_req read (8'h40) in the same cycle → data granted first, d_ack at cycle 3; fetch granted at cycle 4 IDLE, if_ack at cycle 7; starve_cnt=1 then 0.
- Starvation: d_req renewed continuously, if_req held → three data accesses complete, then the fourth grant goes to fetch (starve_cnt==3); after that, data wins again.
- Write: d_req, d_we=1, d_addr=8'h20, d_wdata=32'h12345678 → mem_we and mem_en high exactly 2 cycles with mem_wdata=32'h12345678; d_ack one cycle; d_rdata and if_rdata unchanged.
- Reset mid-access: reset=0 in the second ACCESS cycle → next cycle mem_en=0, busy=0, no ack ever pulsed; the held if_req is regranted after reset=1 and completes normally.
- MEM_LAT=1 build: back-to-back fetches → ack every 3 cycles, mem_en high exactly 1 cycle per access.
